// File: rtl/move_pkg.sv
// Shared types and constants for the move pairing path.
package move_pkg;

  localparam int MOVE_W = 5;
  localparam int STEP_W = 6;

  typedef logic [MOVE_W-1:0] move_t;
  typedef logic [STEP_W-1:0] step_t;

  localparam move_t NULL_MOVE = 5'b00000;

  // One buffered FIFO entry, as stored: {last, move}.
  typedef struct packed {
    logic  last;
    move_t move;
  } fifo_entry_t;

  typedef enum logic [1:0] {
    S_A   = 2'd0,
    S_B   = 2'd1,
    S_OUT = 2'd2
  } pair_state_t;

endpackage

// File: rtl/move_fifo.sv
// First-word-fall-through FIFO; head is valid combinationally whenever fill > 0.
module move_fifo #(
  parameter  int DEPTH = 32,
  parameter  int WIDTH = 6,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [WIDTH-1:0] wdata,
  input  logic          pop,
  output logic [WIDTH-1:0] rdata,
  output logic [AW:0]   fill
);

  localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  // Full blocks a push even when a pop frees a slot in the same cycle.
  assign push_ok = push && (fill != FULL_LVL);
  assign pop_ok  = pop  && (fill != '0);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   fill <= fill + 1'b1;
        2'b01:   fill <= fill - 1'b1;
        default: fill <= fill;
      endcase
    end
  end

endmodule

// File: rtl/step_conversion.sv
// Combinational converter from a pair of one-move moves to one two-move step.
module step_conversion
  import move_pkg::*;
(
  input  logic [MOVE_W-1:0] move_a,
  input  logic [MOVE_W-1:0] move_b,
  output logic [STEP_W-1:0] step
);

  logic [MOVE_W-1:0] b_res;

  // First move scaled by two plus the residue of the second move mod 6.
  assign b_res = move_b % move_t'(6);
  assign step  = {move_a, 1'b0} + {1'b0, b_res};

endmodule

// File: rtl/move_pair_sequencer.sv
// Buffers solver moves, pairs them and presents registered two-move steps downstream.
module move_pair_sequencer
  import move_pkg::*;
#(
  parameter int DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [MOVE_W-1:0]        in_move,
  input  logic                     in_last,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [STEP_W-1:0]        out_step,
  output logic                     out_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   fill
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

  pair_state_t state;
  move_t       reg_a;
  fifo_entry_t head;
  logic [MOVE_W:0] head_raw;
  logic        head_vld;
  logic        push;
  logic        pop;
  move_t       conv_a;
  move_t       conv_b;
  step_t       conv_step;

  assign in_ready = !rst && (fill != FULL_LVL);
  assign push     = in_valid && in_ready;
  assign head     = fifo_entry_t'(head_raw);
  assign head_vld = (fill != '0);
  assign pop      = head_vld && (state != S_OUT);

  move_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (MOVE_W + 1)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata ({in_last, in_move}),
    .pop   (pop),
    .rdata (head_raw),
    .fill  (fill)
  );

  // In S_A the converter only matters for a lone last move, paired with NULL_MOVE.
  assign conv_a = (state == S_A) ? head.move : reg_a;
  assign conv_b = (state == S_A) ? NULL_MOVE : head.move;

  step_conversion u_conv (
    .move_a (conv_a),
    .move_b (conv_b),
    .step   (conv_step)
  );

  assign out_valid = (state == S_OUT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_A;
      reg_a    <= NULL_MOVE;
      out_step <= '0;
      out_last <= 1'b0;
    end else begin
      case (state)
        S_A: begin
          if (head_vld) begin
            reg_a <= head.move;
            if (head.last) begin
              out_step <= conv_step;
              out_last <= 1'b1;
              state    <= S_OUT;
            end else begin
              state <= S_B;
            end
          end
        end
        S_B: begin
          if (head_vld) begin
            out_step <= conv_step;
            out_last <= head.last;
            state    <= S_OUT;
          end
        end
        S_OUT: begin
          if (out_ready) state <= S_A;
        end
        default: state <= S_A;
      endcase
    end
  end

endmodule

// File: tb/tb_move_pair_sequencer.sv
// Directed bench for move_pair_sequencer with a queue-based pairing model.
module tb_move_pair_sequencer;

  localparam int DEPTH = 32;
  localparam int FW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [4:0]    in_move = '0;
  logic          in_last = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [5:0]    out_step;
  logic          out_last;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [FW-1:0] fill;

  move_pair_sequencer #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_move   (in_move),
    .in_last   (in_last),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_step  (out_step),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .fill      (fill)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [5:0] step;
    logic       last;
  } exp_t;

  exp_t       exp_q[$];
  logic [5:0] got_q[$];
  logic       got_last_q[$];
  int         acc_count = 0;
  logic       have_a = 1'b0;
  logic [4:0] a_mv = '0;
  logic       held = 1'b0;
  logic [5:0] hold_step = '0;
  logic       hold_last = 1'b0;
  bit         rand_rdy = 1'b0;

  // Converter reference: 2*A + (B mod 6), modulo 64.
  function automatic logic [5:0] ref_step(input logic [4:0] a, input logic [4:0] b);
    int v;
    v = (2 * int'(a) + int'(b) % 6) % 64;
    return v[5:0];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Pairing model: consecutive accepted moves pair up, a last move closes a pair early.
  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
      have_a <= 1'b0;
      held   <= 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        got_q.push_back(out_step);
        got_last_q.push_back(out_last);
        acc_count <= acc_count + 1;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      held      <= out_valid && !out_ready;
      hold_step <= out_step;
      hold_last <= out_last;
      if (in_valid && in_ready) begin
        if (have_a) begin
          exp_q.push_back({ref_step(a_mv, in_move), in_last});
          have_a <= 1'b0;
        end else if (in_last) begin
          exp_q.push_back({ref_step(in_move, 5'b00000), 1'b1});
        end else begin
          have_a <= 1'b1;
          a_mv   <= in_move;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (held) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_step", 32'(out_step), 32'(hold_step));
        check("hold_last", 32'(out_last), 32'(hold_last));
      end
      if (out_valid) begin
        if (exp_q.size() == 0) check("unexpected_step", 32'(out_valid), 32'd0);
        else begin
          check("step", 32'(out_step), 32'(exp_q[0].step));
          check("step_last", 32'(out_last), 32'(exp_q[0].last));
        end
      end
    end
  end

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1 out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Drive one move and hold it until it is taken; called between edges.
  task automatic send(input logic [4:0] m, input logic l);
    int n = 0;
    in_valid = 1'b1;
    in_move  = m;
    in_last  = l;
    while (!in_ready && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) check("send_timeout", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    out_ready = 1'b1;
    while ((fill != '0 || exp_q.size() != 0 || out_valid) && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, 32'(fill != '0 || exp_q.size() != 0 || out_valid), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, n, pushes, nsteps, start_acc;
    logic pend, l;

    // Reset state
    @(posedge clk); #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_step", 32'(out_step), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_fill", 32'(fill), 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Back-to-back pairs with out_ready high
    out_ready = 1'b1;
    base = got_q.size();
    send(5'b00000, 1'b0); send(5'b00000, 1'b0);
    send(5'b01001, 1'b0); send(5'b11010, 1'b0);
    send(5'b11010, 1'b0); send(5'b10110, 1'b0);
    send(5'b10001, 1'b0); send(5'b10110, 1'b1);
    n = 0;
    while (got_q.size() < base + 4 && n < 100) begin @(posedge clk); #1; n++; end
    check("seq_count", 32'(got_q.size() - base), 32'd4);
    if (got_q.size() >= base + 4) begin
      check("seq_step0", 32'(got_q[base+0]), 32'b000000);
      check("seq_step1", 32'(got_q[base+1]), 32'b010100);
      check("seq_step2", 32'(got_q[base+2]), 32'b111000);
      check("seq_step3", 32'(got_q[base+3]), 32'b100110);
      check("seq_last0", 32'(got_last_q[base+0]), 32'd0);
      check("seq_last1", 32'(got_last_q[base+1]), 32'd0);
      check("seq_last2", 32'(got_last_q[base+2]), 32'd0);
      check("seq_last3", 32'(got_last_q[base+3]), 32'd1);
    end
    drain("seq_drain");

    // Odd sequence: single last move pairs with NULL_MOVE, valid one cycle after pop
    in_valid = 1'b1; in_move = 5'b01001; in_last = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    check("odd_early_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check("odd_valid", 32'(out_valid), 32'd1);
    check("odd_step", 32'(out_step), 32'b010010);
    check("odd_last", 32'(out_last), 32'd1);
    drain("odd_drain");

    // Backpressure: output held while pushes keep filling the FIFO
    out_ready = 1'b0;
    send(5'b00011, 1'b0);
    send(5'b00100, 1'b0);
    @(posedge clk); #1;
    check("bp_valid", 32'(out_valid), 32'd1);
    check("bp_step", 32'(out_step), 32'b001010);
    check("bp_fill0", 32'(fill), 32'd0);
    for (int k = 1; k <= 10; k++) begin
      send(5'(k + 8), k == 10);
      check("bp_fill", 32'(fill), 32'(k));
      check("bp_still_valid", 32'(out_valid), 32'd1);
    end
    drain("bp_drain");

    // Full: in_ready falls at DEPTH, an extra push is dropped
    out_ready = 1'b0;
    pushes = 0;
    in_valid = 1'b1;
    in_last = 1'b0;
    n = 0;
    while (in_ready && n < DEPTH + 10) begin
      in_move = 5'(pushes);
      @(posedge clk); #1;
      pushes++;
      n++;
    end
    check("full_push_count", 32'(pushes), 32'(DEPTH + 2));
    check("full_fill", 32'(fill), 32'(DEPTH));
    check("full_in_ready", 32'(in_ready), 32'd0);
    in_move = 5'b11111;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("full_fill_hold", 32'(fill), 32'(DEPTH));
    drain("full_drain");

    // Wrap-around: 3*DEPTH moves under random out_ready
    start_acc = acc_count;
    nsteps = 0;
    pend = 1'b0;
    rand_rdy = 1'b1;
    for (int i = 0; i < 3 * DEPTH; i++) begin
      l = (i == 3 * DEPTH - 1) || ($urandom_range(0, 7) == 0);
      if (pend) begin nsteps++; pend = 1'b0; end
      else if (l) nsteps++;
      else pend = 1'b1;
      send(5'($urandom_range(0, 31)), l);
    end
    rand_rdy = 1'b0;
    @(posedge clk); #2;
    drain("wrap_drain");
    check("wrap_step_count", 32'(acc_count - start_acc), 32'(nsteps));

    // Reset while in S_B with 5 moves buffered
    out_ready = 1'b0;
    send(5'b00001, 1'b0);
    send(5'b00010, 1'b0);
    for (int k = 3; k <= 8; k++) send(5'(k), 1'b0);
    check("rstb_fill6", 32'(fill), 32'd6);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    check("rstb_fill5", 32'(fill), 32'd5);
    check("rstb_not_valid", 32'(out_valid), 32'd0);
    rst = 1'b1;
    #1;
    check("rstb_in_ready_low", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("rstb_fill", 32'(fill), 32'd0);
    check("rstb_valid", 32'(out_valid), 32'd0);
    check("rstb_step", 32'(out_step), 32'd0);
    check("rstb_in_ready", 32'(in_ready), 32'd1);
    send(5'b10101, 1'b0);
    send(5'b01110, 1'b1);
    n = 0;
    while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
    check("rstb_pair_valid", 32'(out_valid), 32'd1);
    check("rstb_pair_step", 32'(out_step), 32'b101100);
    check("rstb_pair_last", 32'(out_last), 32'd1);
    drain("rstb_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/move_pair_sequencer.md
# move_pair_sequencer

Buffers the solver's stream of 5-bit one-move-format moves and groups consecutive moves into pairs. Each pair goes through the combinational STEP_CONVERSION converter, and the result is presented as registered 6-bit two-move-format steps to the downstream motor/step executor. The block sits between the solver output and the step executor. It decouples their rates with a FIFO and a valid/ready handshake on both sides.

## Interface
Parameters:
- DEPTH, 32, FIFO capacity in moves; power of two, ≥ 4.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_move  in  5  one-move-format move.
- in_last  in  1  marks final move of a sequence.
- in_valid  in  1  in_move/in_last valid.
- in_ready  out  1  block can accept a move this cycle.
- out_step  out  6  two-move-format step (registered).
- out_last  out  1  step contains final move of sequence.
- out_valid  out  1  out_step/out_last valid.
- out_ready  in  1  downstream accepts step.
- fill  out  $clog2(DEPTH)+1  current FIFO occupancy.

## Operation
- FIFO entry = {last, move}, 6 bits. Push on in_valid && in_ready. in_ready = (fill < DEPTH); derived from registered fill only.
- FIFO is first-word-fall-through: head entry is readable combinationally whenever fill > 0.
- Pairing FSM:
  - S_A: if fill > 0, pop head into reg_a/last_a. If head.last, go to S_OUT with B = NULL_MOVE (5'b00000), out_last = 1. Otherwise go to S_B.
  - S_B: if fill > 0, pop head into B, go to S_OUT, out_last = head.last.
  - S_OUT: out_valid = 1. On out_ready go to S_A.
- out_step <= STEP_CONVERSION(reg_a, B). It is registered on the transition into S_OUT and held stable, together with out_last, while out_valid && !out_ready.
- Odd-length sequences: the final move pairs with NULL_MOVE. Moves are never paired across an in_last boundary.
- A move equal to NULL_MOVE on the input is stored and paired like any other; no filtering.
- No push when full, even if a pop occurs the same cycle. A push into an empty FIFO is not poppable in the same cycle.
- Simultaneous push and pop leave fill unchanged; pointers wrap modulo DEPTH.

## Timing
- Reset values: in_ready = 0 during the rst cycle, 1 after. out_step = 0, out_last = 0, out_valid = 0, fill = 0. FSM is in S_A; FIFO pointers are 0.
- Reset mid-operation flushes the FIFO and aborts any pending pair; the held out_step is dropped.
- Latency: move A pushed at edge n and B at edge n+1 → A popped at edge n+1, B popped at edge n+2, out_valid high after edge n+2.
- Single last move pushed at edge n → out_valid high after edge n+1.
- Throughput: at most one step per 3 cycles with out_ready held high. The input accepts one move per cycle until full.
- out_valid, once high, stays high until the cycle out_ready is sampled high.

## Structure
- Package move_pkg:
  - MOVE_W = 5, STEP_W = 6, NULL_MOVE = 5'b00000.
  - typedef move_t, step_t.
  - enum pair_state_t {S_A, S_B, S_OUT}.
- Sub-module move_fifo: parameterised FWFT FIFO with DEPTH and width MOVE_W+1, exposing fill.
- STEP_CONVERSION is instantiated unchanged as the combinational converter.

## Test plan
- Reset then pairs (0,0), (01001,11010), (11010,10110), (10001,10110,last) streamed back-to-back with out_ready = 1 → out_step sequence 000000, 010100, 111000, 100110. out_last is set only on the final step.
- Odd sequence 01001 (last) → one step equal to STEP_CONVERSION(01001,00000), out_last = 1, one cycle after the pop.
- Backpressure: out_ready = 0 for 10 cycles while out_valid is high → out_step/out_last stable, no further pops, and fill rises with each new push.
- Full: push DEPTH moves with out_ready = 0 → in_ready falls when fill = DEPTH. A push attempted while full is not stored, and fill still equals DEPTH after one further cycle.
- Wrap-around: stream 3×DEPTH moves with random out_ready → every step matches the reference pairing and none are lost or duplicated.
- Reset asserted while in S_B with 5 moves buffered → next cycle fill = 0, out_valid = 0, FSM in S_A. The first pair after reset is built only from post-reset moves.
